// File: rtl/gate_alu.sv
// -----------------------------------------------------------------------------
// gate_alu
//   Single-entry registered bitwise ALU with valid/ready handshakes on both
//   sides. Each accepted operand set produces one result one cycle later. The
//   result is also captured in an internal accumulator that later operations
//   can use as operand X.
//
// Parameters
//   WIDTH   operand/result width in bits (1..64)
//   CNT_W   width of the saturating completed-result counter
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set (a, b, op, acc_en) presented
//   in_ready   block can take an operand set this cycle
//   a, b       operands
//   op         operation select:
//              0 NOT X, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 pass b
//   acc_en     use the accumulator in place of a as operand X
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream takes the result this cycle
//   y          result
//   zero       y is all zeros
//   parity     XOR-reduce of y
//   op_cnt     number of consumed results, saturating
// -----------------------------------------------------------------------------
module gate_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  // Even/odd parity of a result word.
  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] acc_r;
  logic             zero_r;
  logic             parity_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] op_cnt_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             consume_s;
  logic [WIDTH-1:0] operand_x_s;
  logic [WIDTH-1:0] result_s;

  // Handshake decode: the output slot frees up in the same cycle it is drained,
  // so backpressure passes straight through to the input side.
  always_comb begin
    in_ready_s = !out_valid_r || out_ready;
    accept_s   = in_valid && in_ready_s;
    consume_s  = out_valid_r && out_ready;
  end

  // Operand X selection and the bitwise operation itself.
  always_comb begin
    operand_x_s = a;
    result_s    = ZERO_W;
    if (acc_en) begin
      operand_x_s = acc_r;
    end else begin
      operand_x_s = a;
    end
    case (op)
      3'd0:    result_s = ~operand_x_s;
      3'd1:    result_s = operand_x_s & b;
      3'd2:    result_s = operand_x_s | b;
      3'd3:    result_s = ~(operand_x_s & b);
      3'd4:    result_s = ~(operand_x_s | b);
      3'd5:    result_s = operand_x_s ^ b;
      3'd6:    result_s = ~(operand_x_s ^ b);
      3'd7:    result_s = b;
      default: result_s = b;
    endcase
  end

  // Result slot, flags and accumulator; an accept in the same cycle as a
  // consume refills the slot so out_valid never drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r         <= ZERO_W;
      acc_r       <= ZERO_W;
      zero_r      <= 1'b1;
      parity_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      y_r         <= result_s;
      acc_r       <= result_s;
      zero_r      <= (result_s == ZERO_W);
      parity_r    <= calc_parity(result_s);
      out_valid_r <= 1'b1;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Completed-result counter, held at its maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_r <= {CNT_W{1'b0}};
    end else if (consume_s && (op_cnt_r != CNT_MAX)) begin
      op_cnt_r <= op_cnt_r + CNT_ONE;
    end else begin
      op_cnt_r <= op_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign zero      = zero_r;
  assign parity    = parity_r;
  assign op_cnt    = op_cnt_r;

endmodule

// File: doc/gate_alu.md
GATE_ALU -- requirements
Module: gate_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set a/b/op/acc_en is presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select (REQ-014).
REQ-010 acc_en  input  1  use accumulator in place of a.
REQ-011 out_valid  output  1  result register holds an unconsumed result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 y  output  WIDTH  result; zero  output  1  y all-zero; parity  output  1  XOR-reduce of y; op_cnt  output  CNT_W  completed results, saturating.

Function
REQ-014 Bitwise op on operand X (a, or acc when acc_en=1) and b: 0 NOT X; 1 X AND b; 2 X OR b; 3 X NAND b; 4 X NOR b; 5 X XOR b; 6 X XNOR b; 7 pass b (load).
REQ-015 All results are exactly WIDTH bits; no carry, no sign extension.
REQ-016 Accept event = in_valid && in_ready; on accept the result is registered into y on the same edge; latency 1 cycle (out_valid rises on the next cycle).
REQ-017 in_ready = !out_valid || out_ready (combinational; single-entry pipeline with pass-through of backpressure).
REQ-018 Consume event = out_valid && out_ready.
REQ-019 Consume without accept: out_valid clears next cycle; y holds its value.
REQ-020 Simultaneous consume and accept: out_valid stays 1, y takes the new result, no bubble.
REQ-021 While out_valid=1 and out_ready=0: y, zero, parity stable; in_ready=0; inputs ignored.
REQ-022 acc register (internal, WIDTH bits) loads the computed result on every accept, regardless of acc_en.
REQ-023 acc_en=1 uses acc value as it stood before the current accept edge.
REQ-024 zero and parity are registered alongside y and always match the current y.
REQ-025 op_cnt increments by 1 on each consume event; saturates at 2^CNT_W-1 (no wrap).
REQ-026 in_valid=0 or in_ready=0: a, b, op, acc_en are don't-care; no state changes except via consume.

Reset
REQ-027 rst=1 at a rising edge: out_valid=0, y=0, acc=0, zero=1, parity=0, op_cnt=0 on the following cycle.
REQ-028 rst overrides accept and consume in the same cycle; in-flight result discarded, not counted.
REQ-029 in_ready=1 throughout and immediately after reset (out_valid=0).

Verification
REQ-030 WIDTH=8, out_ready=1, ops 0..7 with a=0xA5, b=0x3C -> y=0x5A,0x24,0xBD,0xDB,0x42,0x99,0x66,0x3C one cycle after each accept; op_cnt=8.
REQ-031 Accumulate: op7 b=0xF0, then op5 acc_en=1 b=0xFF, then op1 acc_en=1 b=0x0F -> y=0xF0, 0x0F, 0x0F; zero=0, parity=0 on last.
REQ-032 Backpressure: accept a=0xFF b=0xFF op1, hold out_ready=0 for 5 cycles with new in_valid -> y=0xFF stable, in_ready=0, op_cnt unchanged; release -> exactly one consume, then next operand accepted.
REQ-033 Back-to-back streaming, in_valid=out_ready=1 for 10 cycles -> 10 results, no bubbles, out_valid continuous after first.
REQ-034 Saturation: CNT_W=3, 10 consumes -> op_cnt stops at 7.
REQ-035 Reset mid-stream with out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0, zero=1, op_cnt=0; subsequent acc_en=1 op5 b=0x55 yields 0x55.
